// File: rtl/irq_arbiter.sv
// Five-source fixed-priority interrupt arbiter with a CPU request/ack/done handshake
// and a small register file for enables, pending bits and status.
module irq_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       int_ext1,
   input  logic       int_ext2,
   input  logic       tim1_cmp,
   input  logic       tim2_cmp,
   input  logic       tim3_cmp,
   input  logic       reg_wr,
   input  logic [1:0] reg_addr,
   input  logic [7:0] reg_wdata,
   output logic [7:0] reg_rdata,
   output logic       irq_req,
   output logic [2:0] irq_id,
   input  logic       irq_ack,
   input  logic       irq_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } state_e;

   state_e     state_q;
   logic [1:0] extSync1_q;
   logic [1:0] extSync2_q;
   logic [1:0] extPrev_q;
   logic [2:0] timPrev_q;
   logic [4:0] pending_q;
   logic [4:0] pending_d;
   logic [4:0] enable_q;
   logic       gie_q;
   logic [2:0] curId_q;
   logic       irqReq_q;

   logic [1:0] extEdge;
   logic [2:0] timEdge;
   logic [4:0] setVec;
   logic [4:0] ackClr;
   logic [4:0] w1cClr;
   logic [4:0] masked;
   logic [2:0] winId;
   logic       unusedWdata;

   assign unusedWdata = ^reg_wdata[6:5];

   // External lines cross into the clock domain through two flops before edge
   // detection; timer compares are already synchronous and are edge-detected directly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         extSync1_q <= '0;
         extSync2_q <= '0;
         extPrev_q  <= '0;
         timPrev_q  <= '0;
      end else begin
         extSync1_q <= {int_ext2, int_ext1};
         extSync2_q <= extSync1_q;
         extPrev_q  <= extSync2_q;
         timPrev_q  <= {tim3_cmp, tim2_cmp, tim1_cmp};
      end
   end

   always_comb begin
      extEdge = extSync2_q & ~extPrev_q;
      timEdge = {tim3_cmp, tim2_cmp, tim1_cmp} & ~timPrev_q;
      setVec  = {timEdge, extEdge};
      ackClr  = (state_q == REQUEST && irq_ack) ? (5'b00001 << curId_q) : 5'b00000;
      w1cClr  = (reg_wr && reg_addr == 2'd1) ? reg_wdata[4:0] : 5'b00000;
      // A fresh edge beats any clear aimed at the same bit in the same cycle.
      pending_d = (pending_q & ~(ackClr | w1cClr)) | setVec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         enable_q  <= '0;
         gie_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         if (reg_wr && reg_addr == 2'd0) begin
            gie_q    <= reg_wdata[7];
            enable_q <= reg_wdata[4:0];
         end
      end
   end

   // Lowest index wins, so scan from the bottom priority upward.
   always_comb begin
      masked = pending_q & enable_q;
      winId  = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (masked[i]) begin
            winId = 3'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         curId_q  <= 3'd0;
         irqReq_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gie_q && (masked != 5'b00000)) begin
                  state_q  <= REQUEST;
                  curId_q  <= winId;
                  irqReq_q <= 1'b1;
               end
            end
            REQUEST: begin
               if (irq_ack) begin
                  state_q  <= SERVICE;
                  irqReq_q <= 1'b0;
               end
            end
            SERVICE: begin
               if (irq_done) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q  <= IDLE;
               irqReq_q <= 1'b0;
            end
         endcase
      end
   end

   assign irq_req = irqReq_q;
   assign irq_id  = curId_q;

   always_comb begin
      case (reg_addr)
         2'd0:    reg_rdata = {gie_q, 2'b00, enable_q};
         2'd1:    reg_rdata = {3'b000, pending_q};
         2'd2:    reg_rdata = {3'b000, state_q, curId_q};
         default: reg_rdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: walks through request/ack/done sequences,
// priority ordering, masking, set-beats-clear and asynchronous reset.
`timescale 1ns/1ps
module tb_irq_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       int_ext1 = 1'b0;
   logic       int_ext2 = 1'b0;
   logic       tim1_cmp = 1'b0;
   logic       tim2_cmp = 1'b0;
   logic       tim3_cmp = 1'b0;
   logic       reg_wr = 1'b0;
   logic [1:0] reg_addr = 2'd0;
   logic [7:0] reg_wdata = 8'h00;
   logic [7:0] reg_rdata;
   logic       irq_req;
   logic [2:0] irq_id;
   logic       irq_ack = 1'b0;
   logic       irq_done = 1'b0;

   int checks = 0;
   int failures = 0;

   irq_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .int_ext1  (int_ext1),
      .int_ext2  (int_ext2),
      .tim1_cmp  (tim1_cmp),
      .tim2_cmp  (tim2_cmp),
      .tim3_cmp  (tim3_cmp),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .irq_req   (irq_req),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .irq_done  (irq_done)
   );

   always #5 clk = ~clk;

   // Advance a number of rising edges and park just after the last one.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic checkReg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
      reg_addr = addr;
      #1;
      checkOutput(tag, reg_rdata, exp);
   endtask

   task automatic checkIrq(input string tag, input logic req, input logic [2:0] id);
      checkOutput({tag, "_req"}, {7'b0, irq_req}, {7'b0, req});
      checkOutput({tag, "_id"}, {5'b0, irq_id}, {5'b0, id});
   endtask

   task automatic writeReg(input logic [1:0] addr, input logic [7:0] data);
      reg_wr    = 1'b1;
      reg_addr  = addr;
      reg_wdata = data;
      applyStimulus(1);
      reg_wr    = 1'b0;
   endtask

   initial begin
      // Reset state
      applyStimulus(2);
      checkIrq("rst", 1'b0, 3'd0);
      checkReg("rst_ctrl", 2'd0, 8'h00);
      checkReg("rst_pend", 2'd1, 8'h00);
      checkReg("rst_stat", 2'd2, 8'h00);
      reset = 1'b0;
      applyStimulus(1);

      // Single timer-2 interrupt through the full handshake
      writeReg(2'd0, 8'h9F);
      checkReg("ctrl_rb", 2'd0, 8'h9F);
      tim2_cmp = 1'b1;
      applyStimulus(1);
      tim2_cmp = 1'b0;
      checkReg("t2_pend", 2'd1, 8'h08);
      checkOutput("t2_noreq_yet", {7'b0, irq_req}, 8'h00);
      applyStimulus(1);
      checkIrq("t2_req", 1'b1, 3'd3);
      checkReg("t2_stat_req", 2'd2, 8'h0B);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkReg("t2_pend_ack", 2'd1, 8'h00);
      checkReg("t2_stat_svc", 2'd2, 8'h13);
      checkOutput("t2_req_svc", {7'b0, irq_req}, 8'h00);
      irq_done = 1'b1;
      applyStimulus(1);
      irq_done = 1'b0;
      checkReg("t2_stat_idle", 2'd2, 8'h03);

      // ext2 and tim1 rise together: tim1 pends first due to shorter latency
      int_ext2 = 1'b1;
      tim1_cmp = 1'b1;
      applyStimulus(1);
      tim1_cmp = 1'b0;
      checkReg("pri_pend1", 2'd1, 8'h04);
      applyStimulus(1);
      checkIrq("pri_first", 1'b1, 3'd2);
      checkReg("pri_pend2", 2'd1, 8'h04);
      applyStimulus(1);
      checkReg("pri_pend3", 2'd1, 8'h06);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkReg("pri_pend_ack", 2'd1, 8'h02);
      checkReg("pri_stat_svc", 2'd2, 8'h12);
      irq_done = 1'b1;
      applyStimulus(1);
      irq_done = 1'b0;
      checkIrq("pri_gap", 1'b0, 3'd2);
      checkReg("pri_stat_gap", 2'd2, 8'h02);
      applyStimulus(1);
      checkIrq("pri_second", 1'b1, 3'd1);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      irq_done = 1'b1;
      applyStimulus(1);
      irq_done = 1'b0;
      checkReg("pri_level_norearm", 2'd1, 8'h00);
      checkReg("pri_stat_end", 2'd2, 8'h01);
      int_ext2 = 1'b0;

      // Pending latches with gie=0; stray ack/done are ignored
      writeReg(2'd0, 8'h1F);
      tim3_cmp = 1'b1;
      applyStimulus(1);
      tim3_cmp = 1'b0;
      checkReg("gie_pend", 2'd1, 8'h10);
      applyStimulus(1);
      checkOutput("gie_noreq", {7'b0, irq_req}, 8'h00);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      checkReg("ack_idle_stat", 2'd2, 8'h01);
      checkReg("ack_idle_pend", 2'd1, 8'h10);
      writeReg(2'd0, 8'h9F);
      checkOutput("gie_late_noreq", {7'b0, irq_req}, 8'h00);
      applyStimulus(1);
      checkIrq("gie_req", 1'b1, 3'd4);
      irq_done = 1'b1;
      applyStimulus(1);
      irq_done = 1'b0;
      checkReg("done_req_stat", 2'd2, 8'h0C);
      checkReg("done_req_pend", 2'd1, 8'h10);
      checkOutput("done_req_hold", {7'b0, irq_req}, 8'h01);
      irq_ack = 1'b1;
      applyStimulus(1);
      irq_ack = 1'b0;
      irq_done = 1'b1;
      applyStimulus(1);
      irq_done = 1'b0;
      checkReg("t3_end_pend", 2'd1, 8'h00);

      // ext1 latency, request held through clears, set beats W1C
      int_ext1 = 1'b1;
      applyStimulus(1);
      int_ext1 = 1'b0;
      applyStimulus(1);
      checkReg("e1_pend_n1", 2'd1, 8'h00);
      applyStimulus(1);
      checkReg("e1_pend_n2", 2'd1, 8'h01);
      applyStimulus(1);
      checkIrq("e1_req", 1'b1, 3'd0);
      writeReg(2'd1, 8'h01);
      checkOutput("e1_w1c_hold", {7'b0, irq_req}, 8'h01);
      checkReg("e1_w1c_pend", 2'd1, 8'h00);
      writeReg(2'd0, 8'h00);
      checkIrq("e1_ctrl0_hold", 1'b1, 3'd0);
      reg_wr    = 1'b1;
      reg_addr  = 2'd1;
      reg_wdata = 8'h04;
      irq_ack   = 1'b1;
      tim1_cmp  = 1'b1;
      applyStimulus(1);
      reg_wr    = 1'b0;
      irq_ack   = 1'b0;
      tim1_cmp  = 1'b0;
      checkReg("set_wins_pend", 2'd1, 8'h04);
      checkReg("e1_stat_svc", 2'd2, 8'h10);
      checkOutput("e1_req_svc", {7'b0, irq_req}, 8'h00);

      // Asynchronous reset during SERVICE
      int_ext2 = 1'b1;
      applyStimulus(1);
      int_ext2 = 1'b0;
      applyStimulus(2);
      checkReg("svc_pend06", 2'd1, 8'h06);
      writeReg(2'd0, 8'h9F);
      checkReg("svc_nonest", 2'd2, 8'h10);
      #1;
      reset = 1'b1;
      #1;
      checkIrq("arst", 1'b0, 3'd0);
      checkReg("arst_pend", 2'd1, 8'h00);
      checkReg("arst_stat", 2'd2, 8'h00);
      checkReg("arst_ctrl", 2'd0, 8'h00);
      applyStimulus(1);
      reset = 1'b0;
      applyStimulus(1);

      // Enable mask gates the request; addr 3 is inert
      writeReg(2'd0, 8'h81);
      tim1_cmp = 1'b1;
      applyStimulus(1);
      tim1_cmp = 1'b0;
      checkReg("mask_pend", 2'd1, 8'h04);
      applyStimulus(2);
      checkOutput("mask_noreq", {7'b0, irq_req}, 8'h00);
      writeReg(2'd0, 8'h85);
      applyStimulus(1);
      checkIrq("mask_req", 1'b1, 3'd2);
      writeReg(2'd3, 8'hFF);
      checkReg("addr3_rd", 2'd3, 8'h00);
      checkReg("addr3_ctrl", 2'd0, 8'h85);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
